// File: rtl/mdu_pkg.sv
// Shared constants, op encodings and FSM states for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MFHI  = 3'b100,
    OP_MFLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  localparam logic [WIDTH-1:0] DIV0_QUOT = 32'hFFFFFFFF;

endpackage

// File: rtl/mdu_neg32.sv
// Conditional two's-complement negation of one 32-bit word; cin/cout chain words into wider negations.
module mdu_neg32
  import mdu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic             en,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             cout
);

  logic [WIDTH:0] inv_sum;

  assign inv_sum = {1'b0, ~a} + {{WIDTH{1'b0}}, cin};
  assign y       = en ? inv_sum[WIDTH-1:0] : a;
  assign cout    = en & inv_sum[WIDTH];

endmodule

// File: rtl/mdu32.sv
// Iterative 32-bit multiply/divide unit owning HI/LO, with MFHI/MFLO write-back to the register file.
module mdu32
  import mdu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  S,
  input  logic [WIDTH-1:0]  T,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [WIDTH-1:0]  HI,
  output logic [WIDTH-1:0]  LO,
  output logic [WIDTH-1:0]  D,
  output logic              D_En,
  output logic [ADDR_W-1:0] D_Addr
);

  state_e                 state;
  logic [2*WIDTH-1:0]     acc;
  logic [2*WIDTH-1:0]     acc_next;
  logic [WIDTH-1:0]       b_reg;
  logic [5:0]             cnt;
  logic                   sign_a, sign_b, is_signed, is_div;

  logic [WIDTH-1:0]       s_mag, t_mag, lo_fix, hi_fix;
  logic                   s_cout, t_cout, lo_cout;
  logic                   unused_carry;
  logic                   neg_prod, neg_hi, div0;
  logic [WIDTH:0]         add_sum, sub_diff;

  // Operand magnitudes for signed ops (even opcodes are the signed variants).
  mdu_neg32 u_neg_s (.a(S), .en(~op[0] & S[WIDTH-1]), .cin(1'b1), .y(s_mag), .cout(s_cout));
  mdu_neg32 u_neg_t (.a(T), .en(~op[0] & T[WIDTH-1]), .cin(1'b1), .y(t_mag), .cout(t_cout));
  assign unused_carry = s_cout ^ t_cout;

  // Low word doubles as the quotient; for a product its carry feeds the high word.
  assign neg_prod = is_signed & (sign_a ^ sign_b);
  assign neg_hi   = is_div ? (is_signed & sign_a) : neg_prod;
  assign div0     = is_div & (b_reg == '0);

  mdu_neg32 u_fix_lo (.a(acc[WIDTH-1:0]), .en(neg_prod), .cin(1'b1),
                      .y(lo_fix), .cout(lo_cout));
  mdu_neg32 u_fix_hi (.a(acc[2*WIDTH-1:WIDTH]), .en(neg_hi), .cin(is_div ? 1'b1 : lo_cout),
                      .y(hi_fix), .cout());

  assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_reg};
  assign sub_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_reg};

  always_comb begin
    acc_next = acc;
    if (is_div) begin
      if (!sub_diff[WIDTH]) acc_next = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                  acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_next = {add_sum, acc[WIDTH-1:1]};
      else        acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      b_reg       <= '0;
      cnt         <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      is_signed   <= 1'b0;
      is_div      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      HI          <= '0;
      LO          <= '0;
      D           <= '0;
      D_En        <= 1'b0;
      D_Addr      <= '0;
    end else begin
      // NOTE: pulse outputs default low here so each branch only has to raise them.
      done        <= 1'b0;
      D_En        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !op[2]) begin
            acc       <= {{WIDTH{1'b0}}, s_mag};
            b_reg     <= t_mag;
            sign_a    <= S[WIDTH-1];
            sign_b    <= T[WIDTH-1];
            is_signed <= ~op[0];
            is_div    <= op[1];
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= CALC;
          end else if (start && (op == OP_MFHI || op == OP_MFLO)) begin
            D      <= op[0] ? LO : HI;
            D_Addr <= wb_addr;
            D_En   <= (wb_addr != '0);
            done   <= 1'b1;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          HI    <= hi_fix;
          LO    <= div0 ? DIV0_QUOT : lo_fix;
          state <= DONE;
        end
        DONE: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          div_by_zero <= div0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
